bch_test_sequencer: RTL and testbench
=====================================

// Module: bch_test_sequencer
// PURPOSE
//  Synthesizable frame sequencer for the BCH encode -> error-inject -> decode harness.
//  Generates pseudo-random data words and error patterns of 0..T flipped bits from a 32-bit LFSR,
//  then issues frames to the harness via the ready/encode_start handshake.
//  Collects pass/fail results and stops on frame count or first failure.
//  Replaces the behavioural stimulus loop so that long regressions can run on hardware.
// PARAMETERS
//  DATA_BITS   5            message bits per frame
//  CODE_BITS   15           codeword bits (error vector width); requires T < CODE_BITS
//  T           3            maximum correctable errors; nerr range 0..T
//  SEED        32'h1        initial LFSR state; 0 is replaced by 32'h1
//  NUM_FRAMES  1000         frames per run; 0 = run until stopped
// PORTS
//  clk            in   1                 clock
//  reset          in   1                 synchronous, active-high reset
//  start          in   1                 begin run; sampled only in IDLE or DONE
//  stop_on_fail   in   1                 1 = end run on first failing frame
//  dut_ready      in   1                 harness can accept a new frame
//  dut_done       in   1                 1-cycle pulse: current frame finished
//  dut_wrong      in   1                 frame result (valid with dut_done); 1 = mismatch
//  encode_start   out  1                 1-cycle pulse: frame issued
//  data_out       out  DATA_BITS         frame data; stable from encode_start through dut_done
//  error_out      out  CODE_BITS         error mask; popcount == nerr; same stability rule
//  nerr           out  $clog2(T+2)       number of bits set in error_out
//  busy           out  1                 high in every state except IDLE and DONE
//  finished       out  1                 high in DONE
//  frame_count    out  32                frames completed in this run; saturates at 32'hFFFF_FFFF
//  fail_count     out  32                frames with dut_wrong=1; saturates
//  fail_seed      out  32                LFSR state at start of the first failing frame
// BEHAVIOUR
//  Reset (any state, mid-frame included):
//   - state=IDLE; LFSR=SEED (0 is replaced by 1).
//   - All outputs are 0 on the cycle after reset is sampled.
//   - An outstanding frame is abandoned; a later dut_done is ignored.
//  LFSR:
//   - Galois form, x^32+x^22+x^2+x+1, mask 32'h8020_0003.
//   - Advances exactly one step in each GEN_* cycle; holds in all other states.
//  FSM:
//   - IDLE: start -> GEN_DATA. Clears frame_count, fail_count and fail_seed.
//   - GEN_DATA: records the LFSR state as frame_seed.
//     Fills data_out 32 bits per cycle, LSB chunk first; takes ceil(DATA_BITS/32) cycles.
//     Then -> GEN_NERR.
//   - GEN_NERR: candidate = LFSR[$clog2(T+1)-1:0].
//     If candidate <= T: nerr=candidate; clear error_out; remaining=candidate.
//     Otherwise retry next cycle (rejection sampling; no modulo).
//     remaining==0 -> ISSUE; else -> GEN_ERR.
//   - GEN_ERR: one attempt per cycle; idx = LFSR[$clog2(CODE_BITS)-1:0].
//     Accept only if idx < CODE_BITS and error_out[idx]==0: set the bit, remaining--.
//     Otherwise retry. remaining reaches 0 -> ISSUE.
//   - ISSUE: waits while dut_ready=0 (no timeout).
//     On dut_ready=1: encode_start=1 for exactly that one cycle -> WAIT.
//   - WAIT: holds data_out and error_out. On dut_done:
//     - frame_count++.
//     - If dut_wrong: fail_count++; if fail_count was 0, fail_seed<=frame_seed.
//     - Next state priority: (dut_wrong & stop_on_fail) -> DONE;
//       else (NUM_FRAMES!=0 & frame_count+1==NUM_FRAMES) -> DONE; else -> GEN_DATA.
//   - DONE: finished=1; counters and data outputs hold. start -> GEN_DATA with counters cleared.
//     The LFSR continues from its current state; it is not reseeded.
//  Boundary cases:
//   - dut_done outside WAIT is ignored.
//   - dut_done in the same cycle as encode_start is ignored.
//   - start while busy is ignored.
//   - Counters saturate and never wrap.
//   - nerr=0 frames skip GEN_ERR and issue with error_out=0.
//  Latency: start -> first encode_start >= ceil(DATA_BITS/32)+1 cycles (nerr=0, dut_ready=1).
// TESTING
//  - Reset, then start with dut_ready=1 and dut_done 3 cycles after each encode_start:
//    -> the first frame has data_out equal to the low 5 LFSR bits after one step from 32'h1.
//  - NUM_FRAMES=4, dut_wrong=0 -> exactly 4 encode_start pulses; frame_count=4, fail_count=0, finished=1.
//  - dut_wrong=1 on frame 2 with stop_on_fail=1 -> DONE after frame 2; frame_count=2, fail_count=1,
//    fail_seed = frame-2 seed. With stop_on_fail=0 -> run continues to NUM_FRAMES, fail_count=1.
//  - 10000 frames -> every frame has popcount(error_out)==nerr<=T and error_out[CODE_BITS-1:15..]==0;
//    data_out and error_out are unchanged between encode_start and dut_done.
//  - Hold dut_ready=0 for 50 cycles in ISSUE -> no encode_start; pulse fires on the cycle dut_ready rises.
//  - Assert reset during WAIT, then pulse dut_done -> IDLE; all outputs 0; counters unaffected by the dut_done.

Source files
------------

// File: rtl/bch_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bch_test_sequencer
// Purpose  : Frame sequencer for the BCH encode -> error-inject -> decode
//            harness. A 32-bit Galois LFSR produces the data word, the
//            error count (0..T) and the error positions. Each frame is
//            handed to the harness with a ready/encode_start handshake, and
//            the pass/fail result is collected. A run stops after NUM_FRAMES
//            frames or, optionally, on the first failing frame.
// Ports    : clk, reset (sync, active-high)
//            start, stop_on_fail            run control
//            dut_ready, dut_done, dut_wrong harness handshake / result
//            encode_start                   1-cycle frame-issue pulse
//            data_out, error_out, nerr      frame contents
//            busy, finished                 run status
//            frame_count, fail_count        saturating run counters
//            fail_seed                      LFSR state at first failing frame
// Revision : 1.0 - initial release
// ============================================================================
module bch_test_sequencer #(
    parameter int          DATA_BITS  = 5,
    parameter int          CODE_BITS  = 15,
    parameter int          T          = 3,
    parameter logic [31:0] SEED       = 32'h1,
    parameter int          NUM_FRAMES = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop_on_fail,
    input  logic                     dut_ready,
    input  logic                     dut_done,
    input  logic                     dut_wrong,
    output logic                     encode_start,
    output logic [DATA_BITS-1:0]     data_out,
    output logic [CODE_BITS-1:0]     error_out,
    output logic [$clog2(T+2)-1:0]   nerr,
    output logic                     busy,
    output logic                     finished,
    output logic [31:0]              frame_count,
    output logic [31:0]              fail_count,
    output logic [31:0]              fail_seed
);

    localparam int c_CHUNKS    = (DATA_BITS + 31) / 32;
    localparam int c_CHUNK_W   = (c_CHUNKS > 1) ? $clog2(c_CHUNKS) : 1;
    localparam int c_NERR_W    = $clog2(T + 2);
    localparam int c_CAND_W    = (T > 0) ? $clog2(T + 1) : 1;
    localparam int c_IDX_W     = (CODE_BITS > 1) ? $clog2(CODE_BITS) : 1;

    localparam logic [31:0]          c_POLY       = 32'h8020_0003;
    localparam logic [31:0]          c_SEED       = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0]          c_CNT_MAX    = 32'hFFFF_FFFF;
    localparam logic [31:0]          c_T          = 32'(T);
    localparam logic [31:0]          c_CODE_BITS  = 32'(CODE_BITS);
    localparam logic [31:0]          c_LAST_FRAME = 32'(NUM_FRAMES - 1);
    localparam logic [c_CHUNK_W-1:0] c_LAST_CHUNK = c_CHUNK_W'(c_CHUNKS - 1);
    localparam logic [CODE_BITS-1:0] c_BIT0       = CODE_BITS'(1);
    localparam logic [c_NERR_W-1:0]  c_NERR_ONE   = c_NERR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GEN_DATA = 3'd1,
        S_GEN_NERR = 3'd2,
        S_GEN_ERR  = 3'd3,
        S_ISSUE    = 3'd4,
        S_WAIT     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t                 r_state;
    logic [31:0]            r_lfsr;
    logic [31:0]            r_frame_seed;
    logic [c_CHUNK_W-1:0]   r_chunk;
    logic [c_NERR_W-1:0]    r_remaining;

    logic [31:0]            w_lfsr_next;
    logic [c_CAND_W-1:0]    w_cand;
    logic                   w_cand_ok;
    logic [c_IDX_W-1:0]     w_idx;
    logic [CODE_BITS-1:0]   w_idx_onehot;
    logic                   w_idx_ok;
    logic [31:0]            w_frame_inc;
    logic [31:0]            w_fail_inc;
    logic                   w_last_frame;

    // Right-shifting Galois step. Every GEN_* state consumes exactly this
    // one step per cycle; the raw candidate fields are taken from the
    // freshly stepped value.
    assign w_lfsr_next  = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_POLY) : (r_lfsr >> 1);

    // Rejection sampling: out-of-range values are retried, never folded.
    assign w_cand       = w_lfsr_next[c_CAND_W-1:0];
    assign w_cand_ok    = (32'(w_cand) <= c_T);

    // The one-hot shifts to zero for idx >= CODE_BITS, so no out-of-range
    // bit select is ever formed; the range test rejects those indices.
    assign w_idx        = w_lfsr_next[c_IDX_W-1:0];
    assign w_idx_onehot = c_BIT0 << w_idx;
    assign w_idx_ok     = (32'(w_idx) < c_CODE_BITS) && ((error_out & w_idx_onehot) == '0);

    assign w_frame_inc  = (frame_count == c_CNT_MAX) ? frame_count : frame_count + 32'd1;
    assign w_fail_inc   = (fail_count  == c_CNT_MAX) ? fail_count  : fail_count  + 32'd1;
    assign w_last_frame = (NUM_FRAMES != 0) && (frame_count == c_LAST_FRAME);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lfsr       <= c_SEED;
            r_frame_seed <= '0;
            r_chunk      <= '0;
            r_remaining  <= '0;
            encode_start <= 1'b0;
            data_out     <= '0;
            error_out    <= '0;
            nerr         <= '0;
            busy         <= 1'b0;
            finished     <= 1'b0;
            frame_count  <= '0;
            fail_count   <= '0;
            fail_seed    <= '0;
        end else begin
            encode_start <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_GEN_DATA;
                        r_chunk     <= '0;
                        frame_count <= '0;
                        fail_count  <= '0;
                        fail_seed   <= '0;
                        busy        <= 1'b1;
                        finished    <= 1'b0;
                    end
                end

                S_GEN_DATA: begin
                    r_lfsr <= w_lfsr_next;
                    if (r_chunk == '0) begin
                        r_frame_seed <= r_lfsr;
                    end
                    // Only the bits that fall in the current 32-bit chunk
                    // are written; bit b lives in chunk b/32.
                    for (int b = 0; b < DATA_BITS; b++) begin
                        if ((b / 32) == int'(r_chunk)) begin
                            data_out[b] <= w_lfsr_next[b % 32];
                        end
                    end
                    if (r_chunk == c_LAST_CHUNK) begin
                        r_chunk <= '0;
                        r_state <= S_GEN_NERR;
                    end else begin
                        r_chunk <= r_chunk + c_CHUNK_W'(1);
                    end
                end

                S_GEN_NERR: begin
                    r_lfsr <= w_lfsr_next;
                    if (w_cand_ok) begin
                        nerr        <= c_NERR_W'(w_cand);
                        r_remaining <= c_NERR_W'(w_cand);
                        error_out   <= '0;
                        r_state     <= (w_cand == '0) ? S_ISSUE : S_GEN_ERR;
                    end
                end

                S_GEN_ERR: begin
                    r_lfsr <= w_lfsr_next;
                    if (w_idx_ok) begin
                        error_out   <= error_out | w_idx_onehot;
                        r_remaining <= r_remaining - c_NERR_ONE;
                        if (r_remaining == c_NERR_ONE) begin
                            r_state <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (dut_ready) begin
                        encode_start <= 1'b1;
                        r_state      <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // encode_start is high on the first WAIT cycle; a done
                    // seen together with it cannot belong to this frame.
                    if (dut_done && !encode_start) begin
                        frame_count <= w_frame_inc;
                        if (dut_wrong) begin
                            fail_count <= w_fail_inc;
                            if (fail_count == '0) begin
                                fail_seed <= r_frame_seed;
                            end
                        end
                        if ((dut_wrong && stop_on_fail) || w_last_frame) begin
                            r_state  <= S_DONE;
                            busy     <= 1'b0;
                            finished <= 1'b1;
                        end else begin
                            r_state <= S_GEN_DATA;
                            r_chunk <= '0;
                        end
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    busy     <= 1'b0;
                    finished <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bch_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_test_sequencer
// Purpose  : Self-checking bench for bch_test_sequencer (NUM_FRAMES = 4).
//            A reference LFSR model predicts every frame; predictions are
//            queued when a run is started and popped on each encode_start.
//            Run-level outcomes come from a table of vectors, multi-cycle
//            corner cases from hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bch_test_sequencer;

    localparam int          DATA_BITS  = 5;
    localparam int          CODE_BITS  = 15;
    localparam int          T          = 3;
    localparam int          NUM_FRAMES = 4;
    localparam logic [31:0] SEED       = 32'h1;
    localparam int          NERR_W     = $clog2(T + 2);

    logic                  clk = 1'b0;
    logic                  reset, start, stop_on_fail, dut_ready, dut_done, dut_wrong;
    logic                  encode_start, busy, finished;
    logic [DATA_BITS-1:0]  data_out;
    logic [CODE_BITS-1:0]  error_out;
    logic [NERR_W-1:0]     nerr;
    logic [31:0]           frame_count, fail_count, fail_seed;

    always #5 clk = ~clk;

    bch_test_sequencer #(
        .DATA_BITS  (DATA_BITS),
        .CODE_BITS  (CODE_BITS),
        .T          (T),
        .SEED       (SEED),
        .NUM_FRAMES (NUM_FRAMES)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop_on_fail (stop_on_fail),
        .dut_ready    (dut_ready),
        .dut_done     (dut_done),
        .dut_wrong    (dut_wrong),
        .encode_start (encode_start),
        .data_out     (data_out),
        .error_out    (error_out),
        .nerr         (nerr),
        .busy         (busy),
        .finished     (finished),
        .frame_count  (frame_count),
        .fail_count   (fail_count),
        .fail_seed    (fail_seed)
    );

    typedef struct {
        logic [31:0]          seed;
        logic [DATA_BITS-1:0] data;
        logic [CODE_BITS-1:0] err;
        int                   nerr;
    } frame_t;

    typedef struct {
        logic       sof;
        logic [3:0] wrong_mask;
        int         frames;
        int         fails;
        int         seed_idx;   // frame whose seed lands in fail_seed, -1 = none
    } vec_t;

    frame_t      sb_q[$];
    vec_t        vecs[6];
    logic [31:0] model_lfsr;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_pulses = 0;
    bit          first_frame;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        if (encode_start === 1'b1) n_pulses++;
    endtask

    // Predict the next frame from the model LFSR and queue it.
    task automatic push_frame();
        frame_t      f;
        logic [31:0] s;
        int          cand, rem, idx;
        s      = model_lfsr;
        f.seed = s;
        s      = lfsr_step(s);
        f.data = s[DATA_BITS-1:0];
        do begin
            s    = lfsr_step(s);
            cand = int'(s[1:0]);
        end while (cand > T);
        f.nerr = cand;
        f.err  = '0;
        rem    = cand;
        while (rem > 0) begin
            s   = lfsr_step(s);
            idx = int'(s[3:0]);
            if (idx < CODE_BITS && f.err[idx] == 1'b0) begin
                f.err[idx] = 1'b1;
                rem--;
            end
        end
        model_lfsr = s;
        sb_q.push_back(f);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_lfsr = SEED;
        sb_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " encode_start"}, 64'(encode_start), 64'(0));
        check({tag, " data_out"},     64'(data_out),     64'(0));
        check({tag, " error_out"},    64'(error_out),    64'(0));
        check({tag, " nerr"},         64'(nerr),         64'(0));
        check({tag, " busy"},         64'(busy),         64'(0));
        check({tag, " finished"},     64'(finished),     64'(0));
        check({tag, " frame_count"},  64'(frame_count),  64'(0));
        check({tag, " fail_count"},   64'(fail_count),   64'(0));
        check({tag, " fail_seed"},    64'(fail_seed),    64'(0));
    endtask

    // Wait for the next encode_start, compare against the scoreboard, then
    // answer with dut_done three cycles after the pulse. With early=1 a
    // done (wrong=1) and a start are also driven in the pulse cycle itself.
    task automatic serve_frame(input logic wrong, input bit early, output logic [31:0] seed);
        frame_t               e;
        logic [DATA_BITS-1:0] d0;
        logic [CODE_BITS-1:0] e0;
        logic [31:0]          fc0, fl0;
        int                   cnt;
        seed = '0;
        cnt  = 0;
        while (encode_start !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        if (encode_start !== 1'b1) begin
            check("encode_start timeout", 64'(0), 64'(1));
            return;
        end
        if (sb_q.size() == 0) begin
            check("scoreboard underflow", 64'(0), 64'(1));
            return;
        end
        e    = sb_q.pop_front();
        seed = e.seed;
        if (first_frame) begin
            check("first frame data", 64'(data_out), 64'(5'd3));
            first_frame = 1'b0;
        end
        check("data_out",  64'(data_out),  64'(e.data));
        check("error_out", 64'(error_out), 64'(e.err));
        check("nerr",      64'(nerr),      64'(e.nerr));
        check("popcount==nerr", 64'($countones(error_out)), 64'(nerr));
        check("nerr<=T",   64'(nerr <= NERR_W'(T)), 64'(1));
        d0  = data_out;
        e0  = error_out;
        fc0 = frame_count;
        fl0 = fail_count;
        if (early) begin
            dut_done  = 1'b1;
            dut_wrong = 1'b1;
            start     = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            dut_done  = 1'b0;
            dut_wrong = 1'b0;
            start     = 1'b0;
            check("data_out stable",  64'(data_out),  64'(d0));
            check("error_out stable", 64'(error_out), 64'(e0));
        end
        if (early) begin
            check("frame_count after same-cycle done", 64'(frame_count), 64'(fc0));
            check("fail_count after same-cycle done",  64'(fail_count),  64'(fl0));
            check("busy after start while busy",       64'(busy),        64'(1));
        end
        dut_done  = 1'b1;
        dut_wrong = wrong;
        tick();
        dut_done  = 1'b0;
        dut_wrong = 1'b0;
    endtask

    task automatic do_run(input logic sof, input logic [3:0] mask, input int frames,
                          input int fails, input int seed_idx, input int hold, input int early);
        logic [31:0] seeds [4];
        logic [31:0] exp_seed;
        int          p0;
        for (int i = 0; i < 4; i++) seeds[i] = '0;
        stop_on_fail = sof;
        p0 = n_pulses;
        for (int i = 0; i < frames; i++) push_frame();
        if (hold > 0) dut_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (hold > 0) begin
            repeat (hold) tick();
            check("no pulse while not ready", 64'(n_pulses - p0), 64'(0));
            check("busy while held in issue", 64'(busy), 64'(1));
            dut_ready = 1'b1;
            tick();
            check("pulse after ready rises", 64'(encode_start), 64'(1));
        end
        for (int f = 0; f < frames; f++) serve_frame(mask[f], (f == early), seeds[f]);
        repeat (3) tick();
        exp_seed = (seed_idx < 0) ? 32'h0 : seeds[seed_idx];
        check("run finished",    64'(finished),        64'(1));
        check("run busy",        64'(busy),            64'(0));
        check("run frame_count", 64'(frame_count),     64'(frames));
        check("run fail_count",  64'(fail_count),      64'(fails));
        check("run fail_seed",   64'(fail_seed),       64'(exp_seed));
        check("run pulses",      64'(n_pulses - p0),   64'(frames));
        check("run queue empty", 64'(sb_q.size()),     64'(0));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vecs[0] = '{1'b0, 4'b0000, 4, 0, -1};
        vecs[1] = '{1'b1, 4'b0010, 2, 1,  1};
        vecs[2] = '{1'b0, 4'b0010, 4, 1,  1};
        vecs[3] = '{1'b0, 4'b1010, 4, 2,  1};
        vecs[4] = '{1'b1, 4'b0001, 1, 1,  0};
        vecs[5] = '{1'b1, 4'b1000, 4, 1,  3};

        reset = 1'b1; start = 1'b0; stop_on_fail = 1'b0;
        dut_ready = 1'b1; dut_done = 1'b0; dut_wrong = 1'b0;
        do_reset();
        check_all_zero("reset");

        first_frame = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_run(vecs[i].sof, vecs[i].wrong_mask, vecs[i].frames,
                   vecs[i].fails, vecs[i].seed_idx, 0, -1);
            if (i == 0) begin
                // dut_done while in DONE must not count
                dut_done = 1'b1; dut_wrong = 1'b1;
                tick();
                dut_done = 1'b0; dut_wrong = 1'b0;
                tick();
                check("done in DONE frame_count", 64'(frame_count), 64'(4));
                check("done in DONE fail_count",  64'(fail_count),  64'(0));
                check("done in DONE finished",    64'(finished),    64'(1));
            end
        end

        // ready held low in ISSUE; same-cycle done and start-while-busy on frame 1
        do_run(1'b0, 4'b0100, 4, 1, 2, 50, 1);

        // soak: repeated runs restart from DONE without reseeding
        for (int r = 0; r < 500; r++) do_run(1'b0, 4'b0000, 4, 0, -1, 0, -1);

        // reset while a frame is outstanding, then a stale dut_done
        stop_on_fail = 1'b0;
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (encode_start !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        check("pulse before reset", 64'(encode_start), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dut_done = 1'b1; dut_wrong = 1'b1;
        tick();
        dut_done = 1'b0; dut_wrong = 1'b0;
        tick();
        check_all_zero("mid-frame reset");
        model_lfsr = SEED;
        sb_q.delete();

        first_frame = 1'b1;
        do_run(1'b0, 4'b0000, 4, 0, -1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
